// File: rtl/double_byte_serializer.sv
// double_byte_serializer
// Turns a frame of 64-bit double words into a little-endian byte stream,
// least significant byte first, so a frame of N words yields exactly 8*N
// bytes. Word input and byte output are both valid/ready streams.
// A start/length pair opens each frame, and a one-cycle done pulse closes it.

module double_byte_serializer #(
    parameter int WORD_W = 64,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  word_count,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_last
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [2:0]       IDX_LAST = 3'd7;

    state_t              r_state;
    logic [WORD_W-1:0]   r_shreg;
    logic [2:0]          r_byte_idx;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_word_count;

    logic                w_byte_hs;
    logic                w_word_end;
    logic                w_last_word;

    // The word in flight is the final word of the frame. word_count never
    // reaches r_len while bytes are still being emitted, so the length of
    // 2^LEN_W-1 works without the counter overflowing.
    assign w_last_word = (r_word_count == (r_len - LEN_ONE));
    assign w_byte_hs   = (r_state == ST_SHIFT) && m_ready;
    assign w_word_end  = w_byte_hs && (r_byte_idx == IDX_LAST);

    // All outputs are decoded from registered state only, except s_ready.
    // s_ready opens mid-SHIFT exactly on the byte-7 handshake of a non-final
    // word, so a waiting word is taken without a bubble.
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign m_valid    = (r_state == ST_SHIFT);
    assign m_data     = r_shreg[7:0];
    assign m_last     = (r_state == ST_SHIFT) && (r_byte_idx == IDX_LAST) && w_last_word;
    assign word_count = r_word_count;
    assign s_ready    = (r_state == ST_LOAD) || (w_word_end && !w_last_word);

    // Frame FSM: latch the length, load words, shift bytes out, then pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_byte_idx   <= '0;
            r_len        <= '0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_word_count <= '0;
                        if (length != '0) begin
                            r_len   <= length;
                            r_state <= ST_LOAD;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end

                ST_LOAD: begin
                    if (s_valid) begin
                        r_shreg    <= s_data;
                        r_byte_idx <= '0;
                        r_state    <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (m_ready) begin
                        r_shreg    <= r_shreg >> 8;
                        r_byte_idx <= r_byte_idx + 3'd1;
                        if (r_byte_idx == IDX_LAST) begin
                            r_word_count <= r_word_count + LEN_ONE;
                            if (w_last_word) begin
                                r_state <= ST_DONE;
                            end else if (s_valid) begin
                                // Back-to-back word: reload and keep shifting.
                                r_shreg    <= s_data;
                                r_byte_idx <= '0;
                            end else begin
                                r_state <= ST_LOAD;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_double_byte_serializer.sv
// Testbench for double_byte_serializer: directed frames plus random frames.
// The expected byte stream comes from a reference model that splits each
// word into bytes, least significant byte first.
`timescale 1ns/1ps

module tb_double_byte_serializer;

    localparam int WORD_W = 64;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  word_count;
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [7:0]        m_data;
    logic              m_last;

    int tests = 0;
    int fails = 0;

    logic [63:0] src_q[$];
    logic [7:0]  exp_q[$];

    double_byte_serializer #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    64'(busy),       64'd0);
        check({tag, "_done"},    64'(done),       64'd0);
        check({tag, "_wc"},      64'(word_count), 64'd0);
        check({tag, "_s_ready"}, 64'(s_ready),    64'd0);
        check({tag, "_m_valid"}, 64'(m_valid),    64'd0);
        check({tag, "_m_data"},  64'(m_data),     64'd0);
        check({tag, "_m_last"},  64'(m_last),     64'd0);
    endtask

    // Runs one frame of src_q.size() words. gap: idle cycles inserted before
    // presenting each word once the output has drained (0 = back to back).
    // rdy_pct: probability of m_ready per cycle. inject: pulse start mid-frame.
    // abort_at: assert rst once that many bytes have been accepted (0 = never).
    task automatic run_frame(input string name, input int gap, input int rdy_pct,
                             input bit inject, input int abort_at);
        int          n;
        int          acc;
        int          popped;
        int          gapcnt;
        int          cyc;
        int          first_cyc;
        int          last_cyc;
        bit          injected;
        bit          prev_stall;
        bit          exp_valid;
        bit          exp_sready;
        bit          timed_out;
        logic [7:0]  prev_data;
        logic [63:0] w;

        n = src_q.size();
        exp_q.delete();
        foreach (src_q[i]) begin
            w = src_q[i];
            for (int k = 0; k < 8; k++) exp_q.push_back(w[8*k +: 8]);
        end

        @(negedge clk);
        start   = 1'b1;
        length  = LEN_W'(n);
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        length  = LEN_W'($urandom_range(1, 200));

        acc = 0; popped = 0; gapcnt = 0; cyc = 0;
        first_cyc = -1; last_cyc = -1;
        injected = 0; prev_stall = 0; prev_data = '0; timed_out = 0;

        while (popped < 8 * n) begin
            if (cyc > 3000) begin
                check({name, "_timeout"}, 64'd0, 64'd1);
                timed_out = 1;
                break;
            end
            if (abort_at > 0 && popped == abort_at) begin
                rst     = 1'b1;
                s_valid = 1'b0;
                m_ready = 1'b0;
                @(negedge clk);
                #1;
                check_all_zero({name, "_rst"});
                rst = 1'b0;
                $display("[TB] %s: reset after %0d bytes", name, popped);
                return;
            end

            if (popped == 8 * acc) s_valid = (acc < n) && (gapcnt == 0);
            else                   s_valid = (acc < n) && (gap == 0);
            s_data  = s_valid ? src_q[acc] : {$urandom, $urandom};
            m_ready = ($urandom_range(99) < rdy_pct);
            if (inject && !injected && popped == 3) begin
                start    = 1'b1;
                length   = LEN_W'(n + 4);
                injected = 1;
            end else begin
                start = 1'b0;
            end
            #1;

            exp_valid  = (popped < 8 * acc);
            exp_sready = (acc < n) && ((popped == 8 * acc) || (exp_valid && (popped % 8 == 7) && m_ready));

            check({name, "_m_valid"}, 64'(m_valid),    64'(exp_valid));
            check({name, "_s_ready"}, 64'(s_ready),    64'(exp_sready));
            check({name, "_wc"},      64'(word_count), 64'(popped / 8));
            check({name, "_busy"},    64'(busy),       64'd1);
            check({name, "_done"},    64'(done),       64'd0);
            if (prev_stall) check({name, "_stable"}, 64'(m_data), 64'(prev_data));
            if (exp_valid) begin
                check({name, "_m_data"}, 64'(m_data), 64'(exp_q[0]));
                check({name, "_m_last"}, 64'(m_last), 64'(exp_q.size() == 1));
            end else begin
                check({name, "_m_last_idle"}, 64'(m_last), 64'd0);
            end

            prev_stall = exp_valid && !m_ready;
            prev_data  = m_data;
            if (exp_valid && m_ready) begin
                void'(exp_q.pop_front());
                popped++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (popped == 8 * acc) gapcnt = gap;
            end else if (popped == 8 * acc && gapcnt > 0) begin
                gapcnt--;
            end
            if (s_valid && exp_sready) acc++;

            cyc++;
            @(negedge clk);
        end

        start   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        if (timed_out) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        #1;
        check({name, "_end_done"},    64'(done),       64'd1);
        check({name, "_end_busy"},    64'(busy),       64'd1);
        check({name, "_end_m_valid"}, 64'(m_valid),    64'd0);
        check({name, "_end_wc"},      64'(word_count), 64'(n));
        if (gap == 0 && rdy_pct == 100)
            check({name, "_contiguous"}, 64'(last_cyc - first_cyc + 1), 64'(8 * n));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check({name, "_post_done"}, 64'(done),       64'd0);
            check({name, "_post_busy"}, 64'(busy),       64'd0);
            check({name, "_post_wc"},   64'(word_count), 64'(n));
        end
        $display("[TB] %s: %0d words, %0d bytes, %0d cycles", name, n, popped, cyc);
    endtask

    initial begin
        int n;

        rst = 1'b1; start = 1'b0; length = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        $display("[TB] reset: outputs checked");

        src_q = '{64'h3FF0000000000000};
        run_frame("basic", 0, 100, 0, 0);

        src_q = '{64'h3FF0000000000000, 64'hC004000000000000, 64'h0123456789ABCDEF};
        run_frame("stream", 0, 100, 0, 0);

        run_frame("backpressure", 0, 50, 0, 0);

        run_frame("starvation", 5, 100, 0, 0);

        @(negedge clk);
        start = 1'b1; length = '0;
        @(negedge clk);
        start = 1'b0; length = 16'd9;
        #1;
        check("zero_done",    64'(done),    64'd1);
        check("zero_busy",    64'(busy),    64'd1);
        check("zero_m_valid", 64'(m_valid), 64'd0);
        @(negedge clk);
        #1;
        check("zero_done_after",    64'(done),    64'd0);
        check("zero_busy_after",    64'(busy),    64'd0);
        check("zero_m_valid_after", 64'(m_valid), 64'd0);
        $display("[TB] zero_length: done pulse checked");

        src_q = '{{$urandom, $urandom}, {$urandom, $urandom}};
        run_frame("ignored_start", 0, 80, 1, 0);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 5);
            src_q.delete();
            for (int i = 0; i < n; i++) src_q.push_back({$urandom, $urandom});
            run_frame($sformatf("random%0d", r), $urandom_range(0, 3), $urandom_range(30, 100), 0, 0);
        end

        src_q = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
        run_frame("abort", 0, 100, 0, 12);

        src_q = '{64'h0123456789ABCDEF};
        run_frame("after_reset", 0, 100, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
